// File: rtl/linear_seq.sv
// linear_seq: sequential fully-connected layer, data_out = data_in x weights + biases,
// one input element per cycle across OUTPUT_SIZE parallel MAC lanes, signed Q-format
// with saturation. Optional ReLU on the stored results when RELU_EN is defined.
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   enable       start request, sampled only while idle
//   data_in      [COUNT][INPUT_SIZE] activations, captured in LOAD
//   weights      [INPUT_SIZE][OUTPUT_SIZE] weight matrix, captured in LOAD
//   biases       [OUTPUT_SIZE] per-output bias, captured in LOAD
//   busy         high from LOAD through DONE
//   done         one-cycle pulse, all of data_out valid
//   data_out     [COUNT][OUTPUT_SIZE] registered results
module linear_seq #(
    parameter int INPUT_SIZE  = 4,
    parameter int OUTPUT_SIZE = 2,
    parameter int COUNT       = 1,
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int ACC_WIDTH   = 2 * DATA_WIDTH + $clog2(INPUT_SIZE + 1) + 1
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 enable,
    input  logic [COUNT-1:0][INPUT_SIZE-1:0][DATA_WIDTH-1:0]     data_in,
    input  logic [INPUT_SIZE-1:0][OUTPUT_SIZE-1:0][DATA_WIDTH-1:0] weights,
    input  logic [OUTPUT_SIZE-1:0][DATA_WIDTH-1:0]               biases,
    output logic                                                 busy,
    output logic                                                 done,
    output logic [COUNT-1:0][OUTPUT_SIZE-1:0][DATA_WIDTH-1:0]    data_out
);
    localparam int RW = COUNT > 1 ? $clog2(COUNT) : 1;
    localparam int KW = INPUT_SIZE > 1 ? $clog2(INPUT_SIZE) : 1;
    localparam logic signed [ACC_WIDTH-1:0] MAX_V =
        {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MIN_V =
        {{(ACC_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, MAC, STORE, DONE} state_t;

    state_t state, state_next;
    logic [RW-1:0] r;
    logic [KW-1:0] k;
    logic last_k, last_r;
    logic [COUNT-1:0][INPUT_SIZE-1:0][DATA_WIDTH-1:0]       data_q;
    logic [INPUT_SIZE-1:0][OUTPUT_SIZE-1:0][DATA_WIDTH-1:0] weights_q;
    logic [OUTPUT_SIZE-1:0][DATA_WIDTH-1:0]                 biases_q;
    logic signed [ACC_WIDTH-1:0]    acc      [OUTPUT_SIZE];
    logic signed [2*DATA_WIDTH-1:0] prod     [OUTPUT_SIZE];
    logic signed [ACC_WIDTH-1:0]    sum      [OUTPUT_SIZE];
    logic signed [ACC_WIDTH-1:0]    res      [OUTPUT_SIZE];
    logic [DATA_WIDTH-1:0]          sat      [OUTPUT_SIZE];
    logic [DATA_WIDTH-1:0]          res_word [OUTPUT_SIZE];

    assign last_k = k == KW'(INPUT_SIZE - 1);
    assign last_r = r == RW'(COUNT - 1);
    assign busy   = state != IDLE;
    assign done   = state == DONE;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = enable ? LOAD : IDLE;
            LOAD:    state_next = MAC;
            MAC:     state_next = last_k ? STORE : MAC;
            STORE:   state_next = last_r ? DONE : MAC;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-lane product for the current (r, k) and the rounding/saturation path
    // used when a row is stored. The bias is aligned to the Q(2F) accumulator
    // before the arithmetic shift so truncation happens once, toward -inf.
    always_comb begin
        for (int j = 0; j < OUTPUT_SIZE; j++) begin
            prod[j] = $signed(data_q[r][k]) * $signed(weights_q[k][j]);
            sum[j]  = acc[j] + (ACC_WIDTH'($signed(biases_q[j])) <<< FRAC_BITS);
            res[j]  = sum[j] >>> FRAC_BITS;
            sat[j]  = res[j] > MAX_V ? MAX_V[DATA_WIDTH-1:0] :
                      res[j] < MIN_V ? MIN_V[DATA_WIDTH-1:0] : res[j][DATA_WIDTH-1:0];
`ifdef RELU_EN
            res_word[j] = sat[j][DATA_WIDTH-1] ? '0 : sat[j];
`else
            res_word[j] = sat[j];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            r         <= '0;
            k         <= '0;
            data_q    <= '0;
            weights_q <= '0;
            biases_q  <= '0;
            data_out  <= '0;
            for (int j = 0; j < OUTPUT_SIZE; j++) acc[j] <= '0;
        end else begin
            state <= state_next;
            case (state)
                LOAD: begin
                    data_q    <= data_in;
                    weights_q <= weights;
                    biases_q  <= biases;
                    r         <= '0;
                    k         <= '0;
                    for (int j = 0; j < OUTPUT_SIZE; j++) acc[j] <= '0;
                end
                MAC: begin
                    for (int j = 0; j < OUTPUT_SIZE; j++) acc[j] <= acc[j] + ACC_WIDTH'(prod[j]);
                    k <= last_k ? '0 : k + KW'(1);
                end
                STORE: begin
                    for (int j = 0; j < OUTPUT_SIZE; j++) begin
                        data_out[r][j] <= res_word[j];
                        acc[j]         <= '0;
                    end
                    r <= last_r ? '0 : r + RW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_linear_seq.sv
// tb_linear_seq: scoreboard bench for linear_seq (default build and a COUNT=2 batch build).
module tb_linear_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic en2 = 1'b0;
    always #5 clk = ~clk;

    logic [0:0][3:0][15:0] din  = '0;
    logic [3:0][1:0][15:0] w    = '0;
    logic [1:0][15:0]      b    = '0;
    logic                  busy, done;
    logic [0:0][1:0][15:0] dout;

    logic [1:0][2:0][15:0] din2 = '0;
    logic [2:0][3:0][15:0] w2   = '0;
    logic [3:0][15:0]      b2   = '0;
    logic                  busy2, done2;
    logic [1:0][3:0][15:0] dout2;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;
    logic [1:0][15:0]      q1[$];
    int                    t1[$];
    logic [1:0][3:0][15:0] q2[$];
    int                    t2[$];

    linear_seq dut (
        .clk(clk), .rst(rst), .enable(en), .data_in(din), .weights(w), .biases(b),
        .busy(busy), .done(done), .data_out(dout)
    );

    linear_seq #(.INPUT_SIZE(3), .OUTPUT_SIZE(4), .COUNT(2)) dut2 (
        .clk(clk), .rst(rst), .enable(en2), .data_in(din2), .weights(w2), .biases(b2),
        .busy(busy2), .done(done2), .data_out(dout2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: no done within bound", name);
    endtask

    // Monitor: every done pulse pops one expectation and checks results and timing.
    always @(negedge clk) begin
        if (done) begin
            if (q1.size() == 0) chk("unexpected_done", 128'(done), 128'(0));
            else begin
                chk("dout", 128'(dout), 128'(q1.pop_front()));
                chk("done_cycle", 128'(cyc), 128'(t1.pop_front()));
                chk("busy_at_done", 128'(busy), 128'(1));
            end
        end
        if (done2) begin
            if (q2.size() == 0) chk("unexpected_done2", 128'(done2), 128'(0));
            else begin
                chk("dout2", 128'(dout2), 128'(q2.pop_front()));
                chk("done2_cycle", 128'(cyc), 128'(t2.pop_front()));
            end
        end
    end

    task automatic load1(input logic [3:0][15:0] d, input logic [15:0] w0, input logic [15:0] w1,
                         input logic [1:0][15:0] bv);
        din[0] = d;
        for (int i = 0; i < 4; i++) begin
            w[i][0] = w0;
            w[i][1] = w1;
        end
        b = bv;
    endtask

    task automatic run1(input string name, input logic [3:0][15:0] d, input logic [15:0] w0,
                        input logic [15:0] w1, input logic [1:0][15:0] bv,
                        input logic [1:0][15:0] e, input bit pulse);
        int nb = 0;
        bit seen = 0;
        @(negedge clk);
        load1(d, w0, w1, bv);
        en = 1'b1;
        q1.push_back(e);
        t1.push_back(cyc + 7);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) en = 1'b0;
            if (i == 1) begin
                din = 64'({$urandom(), $urandom()});
                w   = 128'({$urandom(), $urandom(), $urandom(), $urandom()});
                b   = 32'($urandom());
            end
            if (pulse && i == 3) en = 1'b1;
            if (pulse && i == 4) en = 1'b0;
            nb += int'(busy);
            seen = done;
        end
        if (!seen) timeout(name);
        else chk({name, "_busy_cycles"}, 128'(nb), 128'(7));
    endtask

    localparam logic [3:0][15:0] D1234 = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
`ifdef RELU_EN
    localparam logic [15:0] NEG5 = 16'h0000;
`else
    localparam logic [15:0] NEG5 = 16'hFB00;
`endif

    initial begin
        int nb, nd;
        bit seen;
        repeat (3) @(negedge clk);
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_dout", 128'(dout), 128'(0));
        chk("rst_busy2", 128'(busy2), 128'(0));
        chk("rst_dout2", 128'(dout2), 128'(0));
        rst = 1'b0;

        run1("basic", D1234, 16'h0080, 16'h0080, '0, {16'h0500, 16'h0500}, 1'b0);
        run1("bias", D1234, 16'h0080, 16'h0080, {16'hFE00, 16'h0100}, {16'h0300, 16'h0600}, 1'b0);
        run1("sat", {4{16'h6400}}, 16'h0100, 16'hFF00, '0, {16'h8000, 16'h7FFF}, 1'b0);
        run1("trunc", {16'h0, 16'h0, 16'h0, 16'h0001}, 16'h0080, 16'hFF80, '0, {16'hFFFF, 16'h0000}, 1'b0);
        run1("act", D1234, 16'hFF80, 16'hFF80, '0, {NEG5, NEG5}, 1'b0);
        run1("pulse", D1234, 16'h0080, 16'hFF80, '0, {NEG5, 16'h0500}, 1'b1);

        // Abort a run with reset three cycles in; no done may follow.
        @(negedge clk);
        load1(D1234, 16'h0080, 16'h0080, '0);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_done", 128'(done), 128'(0));
        chk("abort_dout", 128'(dout), 128'(0));
        rst = 1'b0;
        repeat (15) @(negedge clk);

        run1("fresh", D1234, 16'h0080, 16'h0080, {16'hFE00, 16'h0100}, {16'h0300, 16'h0600}, 1'b0);

        // Enable held high: three back-to-back runs, done every 8 cycles.
        @(negedge clk);
        load1(D1234, 16'h0080, 16'h0080, '0);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            q1.push_back({16'h0500, 16'h0500});
            t1.push_back(cyc + 7 + 8 * i);
        end
        nd = 0;
        for (int i = 0; i < 60 && nd < 3; i++) begin
            @(negedge clk);
            nd += int'(done);
        end
        en = 1'b0;
        if (nd < 3) timeout("held");

        // Batch build: two rows, identity weights plus a summing fourth lane.
        @(negedge clk);
        din2[0] = {16'h0100, 16'h0100, 16'h0100};
        din2[1] = {16'hFF00, 16'h0000, 16'h0200};
        for (int kk = 0; kk < 3; kk++)
            for (int j = 0; j < 4; j++)
                w2[kk][j] = (j == kk || j == 3) ? 16'h0100 : 16'h0000;
        b2 = {16'h0100, 16'h0000, 16'h0000, 16'h0000};
        en2 = 1'b1;
        q2.push_back({{16'h0200, 16'hFF00, 16'h0000, 16'h0200},
                      {16'h0400, 16'h0100, 16'h0100, 16'h0100}});
        t2.push_back(cyc + 10);
        nb = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) en2 = 1'b0;
            if (i == 1) begin
                din2 = 96'({$urandom(), $urandom(), $urandom()});
                w2   = 192'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
                b2   = 64'({$urandom(), $urandom()});
            end
            nb += int'(busy2);
            seen = done2;
        end
        if (!seen) timeout("batch");
        else chk("batch_busy_cycles", 128'(nb), 128'(10));

        repeat (3) @(negedge clk);
        chk("pending_expectations", 128'(q1.size() + q2.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/linear_seq.md
# linear_seq

Sequential, parametrised fully-connected (linear) layer. It computes data_out = data_in × weights + biases over a batch of COUNT rows using OUTPUT_SIZE parallel multiply-accumulate lanes, with one input element consumed per cycle. Arithmetic is signed fixed point with saturation, and an optional ReLU activation can be compiled in. It sits between activation buffers in the network datapath and uses the same enable/done control convention as the existing layer blocks.

## Interface
- INPUT_SIZE, 4, input features per row (≥1)
- OUTPUT_SIZE, 2, output features per row and number of MAC lanes (≥1)
- COUNT, 1, batch rows per run (≥1)
- DATA_WIDTH, 16, width of every data, weight, bias and output word (signed two's complement)
- FRAC_BITS, 8, fractional bits of every word (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS)
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(INPUT_SIZE+1)+1, accumulator width (derived, do not override)

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  start request, sampled only in IDLE
- data_in  in  [COUNT][INPUT_SIZE][DATA_WIDTH]  input activations
- weights  in  [INPUT_SIZE][OUTPUT_SIZE][DATA_WIDTH]  weight matrix
- biases  in  [OUTPUT_SIZE][DATA_WIDTH]  per-output bias
- busy  out  1  high from the cycle after start until done is deasserted
- done  out  1  one-cycle pulse; all of data_out is valid in this cycle
- data_out  out  [COUNT][OUTPUT_SIZE][DATA_WIDTH]  registered results

## Operation
- FSM states: IDLE → LOAD → MAC → STORE → (MAC for the next row | DONE) → IDLE.
- IDLE: busy=0. If enable=1 at an edge, go to LOAD.
- LOAD: capture data_in, weights and biases into internal registers. Inputs may change freely afterwards. Clear row counter r, k counter and all accumulators.
- MAC: for k = 0..INPUT_SIZE-1, one k per cycle. Lane j does acc[j] += data[r][k] * weight[k][j], using a full-precision 2*DATA_WIDTH product sign-extended to ACC_WIDTH. After k = INPUT_SIZE-1, go to STORE.
- STORE: for each lane j:
  - sum = acc[j] + (sign-extended bias[j] << FRAC_BITS)
  - res = sum >>> FRAC_BITS (arithmetic shift; truncation toward −∞)
  - saturate res to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1]
  - apply optional ReLU, then write to data_out[r][j]
  - clear the accumulators. If r = COUNT−1, go to DONE; otherwise r++ and go to MAC.
- DONE: done=1, busy=1 for one cycle, then IDLE.
- enable while busy: ignored, with no queuing. With enable held high, the next run starts at the first edge in IDLE after done.
- Between runs, data_out holds its last values. Rows are overwritten progressively during a run, so data_out is consistent only while done=1 and after it.

## Timing
- Reset values: busy=0, done=0, data_out all 0, state IDLE, counters and accumulators 0.
- Reset has priority over every state. Asserting reset mid-run aborts the run, and no done is produced.
- Latency: if enable is sampled at edge E0, done=1 in the cycle following edge E0+L−1, where L = 2 + COUNT*(INPUT_SIZE+1). For the defaults, L = 7.
- Throughput: one run every L+1 cycles with enable held high.
- The accumulator never overflows: its width covers INPUT_SIZE products plus the bias.

## Configuration
- RELU_EN defined: in STORE, negative saturated results are written as 0; non-negative results pass unchanged.
- RELU_EN undefined: the saturated result is written directly, and negative outputs are preserved.
- No port or latency difference between the two builds.

## Test plan
- Basic run, defaults, Q8.8: data_in = {1.0, 2.0, 3.0, 4.0} (0x0100, 0x0200, 0x0300, 0x0400), all weights 0.5 (0x0080), biases 0 → data_out = {0x0500, 0x0500}. done pulses exactly once, 7 cycles after enable is sampled; busy is high for those 7 cycles.
- Bias: same data and weights with biases {1.0, −2.0} (0x0100, 0xFE00) → data_out {0x0600 (6.0), 0x0300 (3.0)}.
- Saturation: all data 0x6400 (100.0), all weights 0x0100 → 0x7FFF. Weights 0xFF00 (−1.0) → 0x8000. Fractional truncation case: data 0x0001, weight 0x0080 → 0x0000; weight 0xFF80 → 0xFFFF.
- Activation: weights all −0.5 (0xFF80), data {1, 2, 3, 4} → 0xFB00 (−5.0) without RELU_EN, 0x0000 with RELU_EN.
- Batch: COUNT=2, INPUT_SIZE=3, OUTPUT_SIZE=4, rows {1, 1, 1} and {2, 0, −1}, identity-like weights → per-row results match the reference model. done arrives at L = 10, and inputs changed after LOAD do not affect results.
- Control corners:
  - enable pulsed mid-run → ignored, single done.
  - rst asserted at cycle 3 of a run → busy=0, done=0, data_out=0 in the next cycle, and no done appears.
  - A fresh run after reset gives the correct result.
  - enable held high → back-to-back runs with done spaced 8 cycles apart.
